// File: rtl/arqt_lcd_out_port.sv
// Avalon-MM slave that replays Nios II command/character writes as timed
// HD44780-style parallel write cycles, with busy/overrun status for polling.
module arqt_lcd_out_port #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 2,
    parameter int POST_CYC  = 2000,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] POST_LD  = CNT_W'(POST_CYC - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_readdata;
    logic [7:0]       r_lcd_data;
    logic             r_lcd_rs;
    logic             r_lcd_en;
    logic             r_lcd_on;
    logic             r_overrun;

    logic w_wr;
    logic w_busy;
    logic w_xfer_req;
    logic w_start;
    logic w_ovr_set;
    logic w_ovr_clr;
    logic w_cnt_done;

    always_comb begin
        w_wr       = chipselect & ~write_n;
        w_busy     = (r_state != S_IDLE);
        w_xfer_req = w_wr & ~address[1];
        w_start    = w_xfer_req & ~w_busy;
        w_ovr_set  = w_xfer_req & w_busy;
        w_ovr_clr  = w_wr & (address == 2'd2) & writedata[1];
        w_cnt_done = (r_cnt == '0);
    end

    // Transfer sequencer: each timed state reloads the counter with N-1 on entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lcd_data <= 8'h00;
            r_lcd_rs   <= 1'b0;
            r_lcd_en   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_lcd_data <= writedata[7:0];
                        r_lcd_rs   <= address[0];
                        r_cnt      <= SETUP_LD;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_done) begin
                        r_lcd_en <= 1'b1;
                        r_cnt    <= PULSE_LD;
                        r_state  <= S_PULSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (w_cnt_done) begin
                        r_lcd_en <= 1'b0;
                        r_cnt    <= HOLD_LD;
                        r_state  <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_done) begin
                        r_cnt   <= POST_LD;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_cnt_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_lcd_en <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // A dropped write sets overrun even if software clears it on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
            r_lcd_on  <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_ovr_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_wr && (address == 2'd3)) begin
                r_lcd_on <= writedata[0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'h0;
        end else begin
            case (address)
                2'd0:    r_readdata <= {24'h0, r_lcd_data};
                2'd1:    r_readdata <= {31'h0, r_lcd_rs};
                2'd2:    r_readdata <= {30'h0, r_overrun, w_busy};
                default: r_readdata <= {31'h0, r_lcd_on};
            endcase
        end
    end

    assign readdata = r_readdata;
    assign lcd_data = r_lcd_data;
    assign lcd_rs   = r_lcd_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = r_lcd_en;
    assign lcd_on   = r_lcd_on;

endmodule
